mdr_mem_unit: RTL and testbench

- Memory-side stage directly upstream of the datapath bus mux.
- Holds MAR and MDR, and produces BusMuxIn_MDR, the MDR source that the bus mux places on the bus when MDRout is high.
- Runs a multi-cycle memory read/write handshake with ack wait and timeout; loads MDR from the bus or from memory; drives busy/done/err to the control unit.

---
 rtl/mdr_mem_unit.sv | 170 +++++++++++++++++
 tb/tb_mdr_mem_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdr_mem_unit.sv
// mdr_mem_unit: memory-side stage feeding the datapath bus mux.
// Holds MAR and MDR, runs a multi-cycle memory read/write handshake with
// ack wait and timeout, and reports busy/done/err to the control unit.
//
// Ports:
//   clock, clear_n        rising-edge clock, async active-low reset
//   BusMuxOut             datapath bus value (MAR/MDR load source)
//   MARin, MDRin          load MAR / MDR from the bus (IDLE only)
//   Read, Write           start a memory read / write (IDLE only)
//   mem_rdata, mem_ack    memory read data and completion strobe
//   mem_req, mem_we       request (held until ack/timeout), 1=write
//   mem_addr, mem_wdata   address and write data latched at command start
//   BusMuxIn_MDR          MDR contents presented to the bus mux
//   busy, done, err       in-transaction, completion pulse, sticky timeout
module mdr_mem_unit #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 9,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic [DATA_WIDTH-1:0] BusMuxOut,
    input  logic                  MARin,
    input  logic                  MDRin,
    input  logic                  Read,
    input  logic                  Write,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] BusMuxIn_MDR,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            r_state,     w_state;
    logic [ADDR_WIDTH-1:0] r_mar,       w_mar;
    logic [DATA_WIDTH-1:0] r_mdr,       w_mdr;
    logic [CNT_W-1:0]      r_cnt,       w_cnt;
    logic                  r_mem_req,   w_mem_req;
    logic                  r_mem_we,    w_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr,  w_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata;
    logic                  r_busy,      w_busy;
    logic                  r_done,      w_done;
    logic                  r_err,       w_err;

    // State and all output registers; reset also drops mem_req immediately.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state     <= S_IDLE;
            r_mar       <= '0;
            r_mdr       <= '0;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_mar       <= w_mar;
            r_mdr       <= w_mdr;
            r_cnt       <= w_cnt;
            r_mem_req   <= w_mem_req;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_err       <= w_err;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state     = r_state;
        w_mar       = r_mar;
        w_mdr       = r_mdr;
        w_cnt       = r_cnt;
        w_mem_req   = r_mem_req;
        w_mem_we    = r_mem_we;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_err       = r_err;

        case (r_state)
            S_IDLE: begin
                // Read > Write > MDRin; the command uses the pre-edge MAR.
                if (Read) begin
                    w_state    = S_READ;
                    w_mem_addr = r_mar;
                    w_mem_we   = 1'b0;
                    w_mem_req  = 1'b1;
                    w_cnt      = '0;
                    w_err      = 1'b0;
                    w_busy     = 1'b1;
                end else if (Write) begin
                    w_state     = S_WRITE;
                    w_mem_addr  = r_mar;
                    w_mem_wdata = r_mdr;
                    w_mem_we    = 1'b1;
                    w_mem_req   = 1'b1;
                    w_cnt       = '0;
                    w_err       = 1'b0;
                    w_busy      = 1'b1;
                end else if (MDRin) begin
                    w_mdr = BusMuxOut;
                end
                if (MARin) begin
                    w_mar = BusMuxOut[ADDR_WIDTH-1:0];
                end
            end

            S_READ, S_WRITE: begin
                // Ack is checked before the timeout so a last-cycle ack succeeds.
                if (mem_ack) begin
                    if (r_state == S_READ) begin
                        w_mdr = mem_rdata;
                    end
                    w_mem_req = 1'b0;
                    w_busy    = 1'b0;
                    w_done    = 1'b1;
                    w_state   = S_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_mem_req = 1'b0;
                    w_err     = 1'b1;
                    w_busy    = 1'b0;
                    w_done    = 1'b1;
                    w_state   = S_DONE;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end

            S_DONE: begin
                w_state = S_IDLE;
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign BusMuxIn_MDR = r_mdr;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;

endmodule

// File: tb/tb_mdr_mem_unit.sv
// Testbench for mdr_mem_unit: scenario tasks plus randomized transactions
// checked against a transaction-level model of MAR, MDR and err.
module tb_mdr_mem_unit;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 9;
    localparam int          T  = 15;

    logic          clock;
    logic          clear_n;
    logic [DW-1:0] BusMuxOut;
    logic          MARin, MDRin, Read, Write;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] BusMuxIn_MDR;
    logic          busy, done, err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [AW-1:0] m_mar;
    logic [DW-1:0] m_mdr;
    logic          m_err;

    mdr_mem_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
        .clock        (clock),
        .clear_n      (clear_n),
        .BusMuxOut    (BusMuxOut),
        .MARin        (MARin),
        .MDRin        (MDRin),
        .Read         (Read),
        .Write        (Write),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .BusMuxIn_MDR (BusMuxIn_MDR),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one edge; return 1 time unit after it.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_cmds();
        MARin = 1'b0; MDRin = 1'b0; Read = 1'b0; Write = 1'b0;
        mem_ack = 1'b0;
    endtask

    task automatic load_mar(input logic [DW-1:0] v);
        BusMuxOut = v; MARin = 1'b1;
        cyc();
        MARin = 1'b0;
        m_mar = v[AW-1:0];
    endtask

    task automatic load_mdr(input logic [DW-1:0] v);
        BusMuxOut = v; MDRin = 1'b1;
        cyc();
        MDRin = 1'b0;
        m_mdr = v;
        n_checks++;
        if (BusMuxIn_MDR !== v) begin
            n_fail++;
            $display("FAIL load_mdr: got %h expected %h", BusMuxIn_MDR, v);
        end
    endtask

    // One transaction from IDLE. cmd = {Read, Write, MDRin, MARin}.
    // ack_at: edge index after the command at which mem_ack is high (0 = never).
    task automatic run_txn(input string name, input logic [3:0] cmd,
                           input logic [DW-1:0] bus, input int ack_at,
                           input logic [DW-1:0] rdata, input bit noise);
        logic          rd;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata;
        bit            ok;
        int            last;
        rd        = cmd[3];
        exp_addr  = m_mar;
        exp_wdata = m_mdr;
        ok        = (ack_at >= 1) && (ack_at <= T);
        last      = ok ? ack_at : T;

        BusMuxOut = bus;
        {Read, Write, MDRin, MARin} = cmd;
        cyc();
        clear_cmds();
        if (cmd[0]) m_mar = bus[AW-1:0];

        n_checks++;
        if ({mem_req, busy, done, err, mem_we} !== {1'b1, 1'b1, 1'b0, 1'b0, ~rd}) begin
            n_fail++;
            $display("FAIL %s start req/busy/done/err/we: got %b expected %b", name,
                     {mem_req, busy, done, err, mem_we}, {1'b1, 1'b1, 1'b0, 1'b0, ~rd});
        end
        n_checks++;
        if (mem_addr !== exp_addr) begin
            n_fail++;
            $display("FAIL %s start addr: got %h expected %h", name, mem_addr, exp_addr);
        end
        if (!rd) begin
            n_checks++;
            if (mem_wdata !== exp_wdata) begin
                n_fail++;
                $display("FAIL %s wdata: got %h expected %h", name, mem_wdata, exp_wdata);
            end
        end

        for (int c = 1; c <= last; c++) begin
            mem_ack   = (c == ack_at);
            mem_rdata = (c == ack_at) ? rdata : DW'($urandom);
            if (noise) begin
                BusMuxOut = DW'($urandom);
                {Read, Write, MDRin, MARin} = 4'($urandom);
            end
            cyc();
            clear_cmds();
            if (c < last) begin
                n_checks++;
                if ({mem_req, busy, done} !== 3'b110 || mem_addr !== exp_addr) begin
                    n_fail++;
                    $display("FAIL %s wait c=%0d req/busy/done=%b addr=%h expected 110 addr=%h",
                             name, c, {mem_req, busy, done}, mem_addr, exp_addr);
                end
            end
        end

        if (rd && ok) m_mdr = rdata;
        m_err = !ok;
        n_checks++;
        if ({mem_req, busy, done, err} !== {1'b0, 1'b0, 1'b1, m_err}) begin
            n_fail++;
            $display("FAIL %s end req/busy/done/err: got %b expected %b", name,
                     {mem_req, busy, done, err}, {1'b0, 1'b0, 1'b1, m_err});
        end
        n_checks++;
        if (BusMuxIn_MDR !== m_mdr) begin
            n_fail++;
            $display("FAIL %s mdr: got %h expected %h", name, BusMuxIn_MDR, m_mdr);
        end

        // DONE cycle: commands here must be ignored.
        if (noise) begin
            BusMuxOut = DW'($urandom);
            Read = 1'b1; Write = 1'b1; MDRin = 1'b1; mem_ack = 1'b1;
        end
        cyc();
        clear_cmds();
        n_checks++;
        if ({mem_req, busy, done, err} !== {1'b0, 1'b0, 1'b0, m_err} || BusMuxIn_MDR !== m_mdr) begin
            n_fail++;
            $display("FAIL %s after done req/busy/done/err=%b mdr=%h expected %b mdr=%h", name,
                     {mem_req, busy, done, err}, BusMuxIn_MDR, {1'b0, 1'b0, 1'b0, m_err}, m_mdr);
        end
    endtask

    task automatic test_reset();
        clear_n = 1'b0;
        clear_cmds();
        BusMuxOut = '0; mem_rdata = '0;
        m_mar = '0; m_mdr = '0; m_err = 1'b0;
        repeat (2) cyc();
        n_checks++;
        if ({mem_req, mem_we, busy, done, err} !== 5'b0 || mem_addr !== '0 ||
            mem_wdata !== '0 || BusMuxIn_MDR !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got flags=%b addr=%h wd=%h mdr=%h expected all zero",
                     {mem_req, mem_we, busy, done, err}, mem_addr, mem_wdata, BusMuxIn_MDR);
        end
        clear_n = 1'b1;
        cyc();

        // Reset while a read is outstanding.
        load_mdr(32'h1111_2222);
        load_mar(32'h0000_0055);
        Read = 1'b1;
        cyc();
        Read = 1'b0;
        repeat (2) cyc();
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_req: got %b expected 1", mem_req);
        end
        #2 clear_n = 1'b0;
        #1;
        n_checks++;
        if ({mem_req, mem_we, busy, done, err} !== 5'b0 || mem_addr !== '0 ||
            BusMuxIn_MDR !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got flags=%b addr=%h mdr=%h expected all zero",
                     {mem_req, mem_we, busy, done, err}, mem_addr, BusMuxIn_MDR);
        end
        #1 clear_n = 1'b1;
        m_mar = '0; m_mdr = '0; m_err = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        cyc();
        mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({mem_req, busy, done} !== 3'b0 || BusMuxIn_MDR !== '0) begin
                n_fail++;
                $display("FAIL reset_late_ack: req/busy/done=%b mdr=%h expected 000 mdr=0",
                         {mem_req, busy, done}, BusMuxIn_MDR);
            end
            cyc();
        end
    endtask

    task automatic test_bus_load();
        BusMuxOut = 32'hDEAD_BEEF; MDRin = 1'b1;
        cyc();
        MDRin = 1'b0; BusMuxOut = '0;
        m_mdr = 32'hDEAD_BEEF;
        n_checks++;
        if (BusMuxIn_MDR !== 32'hDEAD_BEEF || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL bus_load: mdr=%h req=%b expected deadbeef req=0", BusMuxIn_MDR, mem_req);
        end
    endtask

    task automatic test_read();
        load_mar(32'h0000_0123);
        run_txn("read", 4'b1000, '0, 3, 32'h1234_5678, 1'b0);
    endtask

    task automatic test_write();
        load_mdr(32'hA5A5_A5A5);
        load_mar(32'h0000_01FF);
        run_txn("write", 4'b0100, '0, 1, '0, 1'b0);
    endtask

    task automatic test_timeout();
        load_mdr(32'h0BAD_F00D);
        run_txn("timeout", 4'b1000, '0, 0, '0, 1'b0);
        run_txn("err_clear", 4'b1000, '0, 2, 32'hCAFE_0001, 1'b0);
    endtask

    task automatic test_conflicts();
        load_mdr(32'h5555_AAAA);
        run_txn("rd_wr_mdrin", 4'b1110, 32'h7777_7777, 2, 32'h0F0F_0F0F, 1'b0);
        run_txn("rd_marin", 4'b1001, 32'h0000_0042, 1, 32'h1357_9BDF, 1'b0);
        run_txn("noise_in_read", 4'b1000, '0, 5, 32'h2468_ACE0, 1'b1);
        run_txn("ack_last_cycle", 4'b1000, '0, T, 32'hFEED_FACE, 1'b1);
        run_txn("write_timeout", 4'b0100, '0, 0, '0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [3:0] cmd;
            int         ack_at;
            if ($urandom_range(0, 2) == 0) load_mar(DW'($urandom));
            if ($urandom_range(0, 2) == 0) load_mdr(DW'($urandom));
            cmd    = 4'($urandom);
            if (!cmd[3]) cmd[2] = 1'b1;
            ack_at = $urandom_range(0, T + 2);
            run_txn("random", cmd, DW'($urandom), ack_at, DW'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_bus_load();
        test_read();
        test_write();
        test_timeout();
        test_conflicts();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
